// File: rtl/i2c_tx_arbiter.sv
// Round-robin arbiter multiplexing NUM_REQ byte producers onto the i2c slave TX FIFO write port.
// Optional stall timeout is enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int MAX_BURST   = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        ack,
  input  logic                      fifo_full,
  output logic                      write_enable,
  output logic [DATA_W-1:0]         write_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic                      timeout
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [7:0]         burst_cnt_q, burst_cnt_d;

  logic [DATA_W-1:0]  data_arr [NUM_REQ];
  logic               found;
  logic [IDX_W-1:0]   pick;
  logic               accept;
  logic               last_beat;
  logic               release_w;
  logic               to_fire;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  // Rotating-priority search starting just after the last released index.
  always_comb begin
    int cand;
    found = 1'b0;
    pick  = ptr_q;
    cand  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(ptr_q) + k) % NUM_REQ;
      if (!found && req[IDX_W'(cand)]) begin
        found = 1'b1;
        pick  = IDX_W'(cand);
      end
    end
  end

  assign busy      = (state_q == S_BURST);
  assign accept    = busy & req[gidx_q] & ~fifo_full;
  assign last_beat = accept & (req_last[gidx_q] | (burst_cnt_q == 8'(MAX_BURST-1)));

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int ST_W = $clog2(TIMEOUT_CYC + 1);

  logic [ST_W-1:0] stall_cnt_q, stall_cnt_d;
  logic            stall;

  assign stall   = busy & req[gidx_q] & fifo_full;
  assign to_fire = stall & (stall_cnt_q == ST_W'(TIMEOUT_CYC-1));

  // Only uninterrupted stalls accumulate; accept, withdraw and release all clear it.
  always_comb begin
    stall_cnt_d = '0;
    if (stall && !to_fire) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end
`else
  assign to_fire = 1'b0;
`endif

  assign release_w = busy & (last_beat | ~req[gidx_q] | to_fire);

  always_comb begin
    state_d     = state_q;
    gidx_d      = gidx_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d     = S_BURST;
          gidx_d      = pick;
          grant_d     = NUM_REQ'(1) << pick;
          burst_cnt_d = '0;
        end
      end
      S_BURST: begin
        if (accept) begin
          burst_cnt_d = burst_cnt_q + 8'd1;
        end
        if (release_w) begin
          state_d     = S_IDLE;
          grant_d     = '0;
          ptr_d       = gidx_q;
          burst_cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gidx_q      <= '0;
      ptr_q       <= IDX_W'(NUM_REQ-1);
      grant_q     <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      gidx_q      <= gidx_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Write-port outputs follow the registered grant so reset silences them at once.
  assign write_enable = accept;
  assign write_data   = accept ? data_arr[gidx_q] : '0;
  assign ack          = accept ? grant_q : '0;
  assign grant        = grant_q;
  assign timeout      = to_fire;

endmodule
